// File: rtl/aes_decrypt_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_if
// Brief    : Request/result bundle for the AES-128 decryption core.
// Revision : 1.0
// ============================================================================
interface aes_decrypt_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;

    modport master (output start, key, ciphertext, input  plaintext, busy, done);
    modport slave  (input  start, key, ciphertext, output plaintext, busy, done);
endinterface
`default_nettype wire

// File: rtl/aes_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt
// Brief    : Iterative AES-128 decryptor, one inverse round per clock, with
//            on-the-fly inverse key schedule and optional round-key-10 cache.
// Revision : 1.0
// ============================================================================
module aes_decrypt #(
    parameter int KEY_CACHE = 1
) (
    input  wire          clk,
    input  wire          rst_n,
    aes_decrypt_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         w_busy;
    logic [127:0] r_state_data;
    logic [127:0] r_round_key;
    logic [3:0]   r_cnt;
    logic [127:0] r_plaintext;
    logic         r_done;
    logic         r_cache_valid;
    logic [127:0] r_cache_key;
    logic [127:0] r_cache_rk10;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        s = gf_inv(x);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]}
                 ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] v;
        case (n)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Byte n of the state sits at bits [127-8n -: 8], n = row + 4*column.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(k + 4*c) -: 8];
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = gf_mul(8'h0e, a[r])           ^ gf_mul(8'h0b, a[(r + 1) % 4])
                                          ^ gf_mul(8'h0d, a[(r + 2) % 4]) ^ gf_mul(8'h09, a[(r + 3) % 4]);
        end
        return o;
    endfunction

    // Forward and inverse schedule steps share one SubWord: the forward step
    // feeds it w3, the inverse step feeds it the recovered w3 (= w3 ^ w2).
    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [31:0]  w_sw_in;
    logic [31:0]  w_temp;
    logic [31:0]  w_f0, w_f1, w_f2;
    logic [127:0] w_key_fwd;
    logic [127:0] w_key_inv;
    logic [127:0] w_inv_sr_sb;
    logic [127:0] w_round_out;
    logic         w_cache_hit;

    assign {w_k0, w_k1, w_k2, w_k3} = r_round_key;
    assign w_sw_in     = (r_state == S_KEXP) ? w_k3 : (w_k3 ^ w_k2);
    assign w_temp      = sub_word({w_sw_in[23:0], w_sw_in[31:24]}) ^ {rcon(r_cnt), 24'h000000};
    assign w_f0        = w_k0 ^ w_temp;
    assign w_f1        = w_k1 ^ w_f0;
    assign w_f2        = w_k2 ^ w_f1;
    assign w_key_fwd   = {w_f0, w_f1, w_f2, w_k3 ^ w_f2};
    assign w_key_inv   = {w_k0 ^ w_temp, w_k1 ^ w_k0, w_k2 ^ w_k1, w_k3 ^ w_k2};
    assign w_inv_sr_sb = inv_sub_bytes(inv_shift_rows(r_state_data));
    assign w_round_out = inv_mix_columns(w_inv_sr_sb ^ r_round_key);
    assign w_cache_hit = (KEY_CACHE != 0) && r_cache_valid && (bus.key == r_cache_key);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_state_next = w_cache_hit ? S_INIT : S_KEXP;
            end
            S_KEXP:  if (r_cnt == 4'd10) w_state_next = S_INIT;
            S_INIT:  w_state_next = S_ROUND;
            S_ROUND: if (r_cnt == 4'd1) w_state_next = S_FINAL;
            S_FINAL: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_data  <= '0;
            r_round_key   <= '0;
            r_cnt         <= 4'd0;
            r_plaintext   <= '0;
            r_done        <= 1'b0;
            r_cache_valid <= 1'b0;
            r_cache_key   <= '0;
            r_cache_rk10  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_state_data <= bus.ciphertext;
                    if (w_cache_hit) begin
                        r_round_key <= r_cache_rk10;
                        r_cnt       <= 4'd10;
                    end else begin
                        // Tag is captured now but only trusted once rk10 lands.
                        r_round_key   <= bus.key;
                        r_cnt         <= 4'd1;
                        r_cache_key   <= bus.key;
                        r_cache_valid <= 1'b0;
                    end
                end
                S_KEXP: begin
                    r_round_key <= w_key_fwd;
                    if (r_cnt == 4'd10) begin
                        r_cache_rk10  <= w_key_fwd;
                        r_cache_valid <= (KEY_CACHE != 0);
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_INIT: begin
                    r_state_data <= r_state_data ^ r_round_key;
                    r_round_key  <= w_key_inv;
                    r_cnt        <= r_cnt - 4'd1;
                end
                S_ROUND: begin
                    r_state_data <= w_round_out;
                    r_round_key  <= w_key_inv;
                    r_cnt        <= r_cnt - 4'd1;
                end
                S_FINAL: begin
                    r_plaintext <= w_inv_sr_sb ^ r_round_key;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.plaintext = r_plaintext;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decrypt
// Brief    : Self-checking bench for aes_decrypt: known answers, cache timing,
//            start/reset behaviour and random loopback via an AES-128 model.
// Revision : 1.0
// ============================================================================
module tb_aes_decrypt;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_decrypt_if bus ();

    aes_decrypt #(.KEY_CACHE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   sb [256];
    logic [127:0] rk10_seen;
    logic         m_cache_valid;
    logic [127:0] m_cache_key;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= t;
            t = xt(t);
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse, then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                sb[x][i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                         ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [7:0]   rc = 8'h01;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ w[n/4][31 - 8*(n%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10)
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            for (int n = 0; n < 16; n++) s[n] ^= w[4*rnd + n/4][31 - 8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) o[127 - 8*n -: 8] = s[n];
        return o;
    endfunction

    // Expected latency from the cache model; updates the model for the job.
    function automatic int model_latency(input logic [127:0] k);
        int lat;
        lat = (m_cache_valid && k == m_cache_key) ? 11 : 21;
        m_cache_valid = 1'b1;
        m_cache_key   = k;
        return lat;
    endfunction

    // busy_n counts busy cycles strictly between the acceptance cycle and done.
    task automatic run_job(input logic [127:0] k, input logic [127:0] c,
                           output int lat, output int busy_n);
        bus.key = k; bus.ciphertext = c; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_accept", 128'(bus.busy), 128'd1);
        lat = 0; busy_n = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) rk10_seen = dut.r_round_key;
            if (bus.busy === 1'b1 && bus.done !== 1'b1) busy_n++;
        end
        if (bus.done !== 1'b1) check("done_timeout", 128'(bus.done), 128'd1);
        check("busy_in_done_cycle", 128'(bus.busy), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n, dones, done_at, exp_lat;
        logic [127:0] k, p, c, prev_k;

        bus.start = 1'b0; bus.key = '0; bus.ciphertext = '0;
        rst_n = 1'b0;
        m_cache_valid = 1'b0; m_cache_key = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("reset_plaintext", bus.plaintext, '0);
        check("reset_busy", 128'(bus.busy), 128'd0);
        check("reset_done", 128'(bus.done), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(K1, C1, lat, busy_n);
        check("c1_plaintext", bus.plaintext, P1);
        check("c1_latency", 128'(model_latency(K1)), 128'(lat));
        check("c1_busy_cycles", 128'(busy_n), 128'd20);

        run_job(KB, CB, lat, busy_n);
        check("b_plaintext", bus.plaintext, PB);
        check("b_latency", 128'(lat), 128'(model_latency(KB)));
        check("b_rk10", rk10_seen, RB);

        // Issued in the done cycle of the previous job.
        run_job(KB, CB, lat, busy_n);
        check("hit_plaintext", bus.plaintext, PB);
        check("hit_latency", 128'(lat), 128'd11);
        void'(model_latency(KB));

        // Changed key plus stray start pulses mid-job with scrambled inputs.
        exp_lat = model_latency(K1);
        bus.key = K1; bus.ciphertext = C1; bus.start = 1'b1;
        @(posedge clk); #1;
        dones = 0; done_at = 0;
        for (int i = 1; i <= 30; i++) begin
            bus.start = (i == 3 || i == 10);
            bus.key        = {$urandom, $urandom, $urandom, $urandom};
            bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                dones++;
                if (done_at == 0) done_at = i;
            end
        end
        bus.start = 1'b0;
        check("ignore_start_done_count", 128'(dones), 128'd1);
        check("ignore_start_latency", 128'(done_at), 128'(exp_lat));
        check("ignore_start_plaintext", bus.plaintext, P1);

        // Abort a cache-hit job mid-round with a one-cycle reset.
        bus.key = K1; bus.ciphertext = C1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_cache_valid = 1'b0;
        check("abort_plaintext", bus.plaintext, '0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        check("abort_done", 128'(bus.done), 128'd0);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", 128'(dones), 128'd0);

        run_job(K1, C1, lat, busy_n);
        check("post_abort_plaintext", bus.plaintext, P1);
        check("post_abort_latency", 128'(lat), 128'(model_latency(K1)));

        // Random loopback; every fourth job reuses the previous key.
        prev_k = K1;
        for (int i = 0; i < 100; i++) begin
            k = (i % 4 == 3) ? prev_k : {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            c = ref_encrypt(k, p);
            exp_lat = model_latency(k);
            run_job(k, c, lat, busy_n);
            check("loop_plaintext", bus.plaintext, p);
            check("loop_latency", 128'(lat), 128'(exp_lat));
            prev_k = k;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
